// File: rtl/grf_wr_arbiter_if.sv
// Bundle of the WB request, MD result handshake and GRF write-port signals
// around grf_wr_arbiter. slave is the arbiter's view, master the environment's.
interface grf_wr_arbiter_if;
   logic        wb_we;
   logic [4:0]  wb_a3;
   logic [31:0] wb_wd;
   logic [31:0] wb_pc;
   logic        wb_stall;

   logic        md_valid;
   logic [4:0]  md_a3;
   logic [31:0] md_wd;
   logic [31:0] md_pc;
   logic        md_ready;

   logic        grf_we;
   logic [4:0]  grf_a3;
   logic [31:0] grf_wd;
   logic [31:0] grf_pc;
   logic        md_pending;

   modport slave (
      input  wb_we, wb_a3, wb_wd, wb_pc,
      input  md_valid, md_a3, md_wd, md_pc,
      output wb_stall, md_ready,
      output grf_we, grf_a3, grf_wd, grf_pc, md_pending
   );

   modport master (
      output wb_we, wb_a3, wb_wd, wb_pc,
      output md_valid, md_a3, md_wd, md_pc,
      input  wb_stall, md_ready,
      input  grf_we, grf_a3, grf_wd, grf_pc, md_pending
   );
endinterface

// File: rtl/grf_wr_arbiter.sv
// Shares the GRF write port between WB (priority) and a 2-entry MD result FIFO.
// Define GRF_ARB_STARVE_GUARD_EN to force an MD grant after STARVE_LIMIT WB wins.
module grf_wr_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic               clk,
   input logic               reset,
   grf_wr_arbiter_if.slave   io_arb
);

   typedef struct packed {
      logic [4:0]  a3;
      logic [31:0] wd;
      logic [31:0] pc;
   } entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } fill_e;

   fill_e  r_count;
   logic   r_wr_ptr;
   logic   r_rd_ptr;
   entry_t r_mem [2];

   logic   w_md_ready;
   logic   w_push;
   logic   w_wb_req;
   logic   w_force;
   logic   w_grant_wb;
   logic   w_grant_md;
   entry_t w_head;

   // md_ready looks only at registered fill level, so no md_* -> output path exists
   assign w_md_ready = (r_count != FULL) && !reset;
   assign w_push     = io_arb.md_valid && w_md_ready && (io_arb.md_a3 != 5'd0);
   assign w_wb_req   = io_arb.wb_we && (io_arb.wb_a3 != 5'd0);
   assign w_head     = r_mem[r_rd_ptr];

   assign w_grant_wb = !reset && w_wb_req && !w_force;
   assign w_grant_md = !reset && (r_count != EMPTY) && (w_force || !w_wb_req);

`ifdef GRF_ARB_STARVE_GUARD_EN
   logic [3:0] r_starve_cnt;

   assign w_force         = (r_count != EMPTY) && (r_starve_cnt == 4'(STARVE_LIMIT));
   assign io_arb.wb_stall = !reset && w_force && w_wb_req;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_starve_cnt <= 4'd0;
      end else if ((r_count == EMPTY) || w_grant_md) begin
         r_starve_cnt <= 4'd0;
      end else if (w_grant_wb) begin
         r_starve_cnt <= r_starve_cnt + 4'd1;
      end
   end
`else
   assign w_force         = 1'b0;
   assign io_arb.wb_stall = 1'b0;
`endif

   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count  <= EMPTY;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
      end else begin
         if (w_push)     r_wr_ptr <= ~r_wr_ptr;
         if (w_grant_md) r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_grant_md})
            2'b10:   r_count <= (r_count == EMPTY) ? ONE : FULL;
            2'b01:   r_count <= (r_count == FULL) ? ONE : EMPTY;
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage has no reset; count/pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= '{a3: io_arb.md_a3, wd: io_arb.md_wd, pc: io_arb.md_pc};
      end
   end

   // NOTE: every output gets a default first so the mux cannot infer a latch.
   always_comb begin
      io_arb.grf_we = 1'b0;
      io_arb.grf_a3 = 5'd0;
      io_arb.grf_wd = 32'd0;
      io_arb.grf_pc = 32'd0;
      if (w_grant_wb) begin
         io_arb.grf_we = 1'b1;
         io_arb.grf_a3 = io_arb.wb_a3;
         io_arb.grf_wd = io_arb.wb_wd;
         io_arb.grf_pc = io_arb.wb_pc;
      end else if (w_grant_md) begin
         io_arb.grf_we = 1'b1;
         io_arb.grf_a3 = w_head.a3;
         io_arb.grf_wd = w_head.wd;
         io_arb.grf_pc = w_head.pc;
      end
   end

   assign io_arb.md_ready   = w_md_ready;
   assign io_arb.md_pending = (r_count != EMPTY);

endmodule

// File: tb/tb_grf_wr_arbiter.sv
// Self-checking bench for grf_wr_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a queue model.
module tb_grf_wr_arbiter;

   localparam int unsigned LIMIT = 4;
`ifdef GRF_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   model_en = 1'b0;

   grf_wr_arbiter_if bus ();

   grf_wr_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk    (clk),
      .reset  (reset),
      .io_arb (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   typedef struct {
      logic [4:0]  a3;
      logic [31:0] wd;
      logic [31:0] pc;
   } ent_t;

   ent_t q[$];
   int   starve = 0;
   logic m_wb_req, m_force, m_gmd, m_gwb;
   logic [31:0] e_we, e_a3, e_wd, e_pc, e_stall, e_ready, e_pend;

   // Outputs are checked mid-cycle; the model then advances to the state after the next edge.
   always @(negedge clk) begin
      if (model_en) begin
         m_wb_req = bus.wb_we && (bus.wb_a3 != 0);
         m_force  = GUARD && (q.size() != 0) && (starve == LIMIT);
         m_gmd    = !reset && (q.size() != 0) && (m_force || !m_wb_req);
         m_gwb    = !reset && m_wb_req && !m_force;
         e_we = 0; e_a3 = 0; e_wd = 0; e_pc = 0;
         if (m_gwb) begin
            e_we = 1; e_a3 = 32'(bus.wb_a3); e_wd = bus.wb_wd; e_pc = bus.wb_pc;
         end else if (m_gmd) begin
            e_we = 1; e_a3 = 32'(q[0].a3); e_wd = q[0].wd; e_pc = q[0].pc;
         end
         e_stall = 32'(!reset && m_force && m_wb_req);
         e_ready = 32'(!reset && (q.size() < 2));
         e_pend  = 32'(q.size() != 0);

         check("m_grf_we",     32'(bus.grf_we),     e_we);
         check("m_grf_a3",     32'(bus.grf_a3),     e_a3);
         check("m_grf_wd",     bus.grf_wd,          e_wd);
         check("m_grf_pc",     bus.grf_pc,          e_pc);
         check("m_wb_stall",   32'(bus.wb_stall),   e_stall);
         check("m_md_ready",   32'(bus.md_ready),   e_ready);
         check("m_md_pending", 32'(bus.md_pending), e_pend);

         if (reset) begin
            q.delete();
            starve = 0;
         end else begin
            if ((q.size() == 0) || m_gmd) starve = 0;
            else if (m_gwb)               starve++;
            if (m_gmd) void'(q.pop_front());
            if (bus.md_valid && e_ready[0] && (bus.md_a3 != 0))
               q.push_back('{a3: bus.md_a3, wd: bus.md_wd, pc: bus.md_pc});
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic set_wb(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                         input logic [31:0] pc);
      bus.wb_we = we; bus.wb_a3 = a3; bus.wb_wd = wd; bus.wb_pc = pc;
   endtask

   task automatic set_md(input logic v, input logic [4:0] a3, input logic [31:0] wd,
                         input logic [31:0] pc);
      bus.md_valid = v; bus.md_a3 = a3; bus.md_wd = wd; bus.md_pc = pc;
   endtask

   initial begin
      set_wb(0, 0, 0, 0);
      set_md(0, 0, 0, 0);
      reset = 1'b1;
      tick();
      model_en = 1'b1;
      tick();
      reset = 1'b0;

      // reset then idle
      for (int i = 0; i < 3; i++) begin
         mid();
         check("idle_md_ready", 32'(bus.md_ready), 1);
         check("idle_grf_we", 32'(bus.grf_we), 0);
         check("idle_md_pending", 32'(bus.md_pending), 0);
         tick();
      end

      // WB only, same-cycle write
      set_wb(1, 5'd5, 32'h1234, 32'h3000);
      mid();
      check("wb_grf_we", 32'(bus.grf_we), 1);
      check("wb_grf_a3", 32'(bus.grf_a3), 5);
      check("wb_grf_wd", bus.grf_wd, 32'h1234);
      check("wb_grf_pc", bus.grf_pc, 32'h3000);
      tick();
      set_wb(1, 5'd0, 32'h1234, 32'h3004);
      mid();
      check("wb_a3zero_we", 32'(bus.grf_we), 0);
      check("wb_a3zero_stall", 32'(bus.wb_stall), 0);
      tick();

      // MD with WB idle: accepted at edge N, written in cycle N+1
      set_wb(0, 0, 0, 0);
      set_md(1, 5'd8, 32'hAAAA, 32'h4000);
      mid();
      check("md_no_bypass", 32'(bus.grf_we), 0);
      tick();
      set_md(0, 0, 0, 0);
      mid();
      check("md_grf_we", 32'(bus.grf_we), 1);
      check("md_grf_a3", 32'(bus.grf_a3), 8);
      check("md_grf_wd", bus.grf_wd, 32'hAAAA);
      tick();
      mid();
      check("md_pending_clear", 32'(bus.md_pending), 0);
      tick();

      // FIFO fill behind busy WB, then drain
      set_wb(1, 5'd3, 32'h3333, 32'h5000);
      set_md(1, 5'd1, 32'h1111, 32'h6000);
      tick();
      set_md(1, 5'd2, 32'h2222, 32'h6004);
      tick();
      set_md(0, 0, 0, 0);
      mid();
      check("fill_md_ready", 32'(bus.md_ready), 0);
      check("fill_grf_a3", 32'(bus.grf_a3), 3);
      check("fill_pending", 32'(bus.md_pending), 1);
      tick();
      set_wb(0, 0, 0, 0);
      mid();
      check("drain1_a3", 32'(bus.grf_a3), 1);
      check("drain1_wd", bus.grf_wd, 32'h1111);
      tick();
      mid();
      check("drain2_a3", 32'(bus.grf_a3), 2);
      check("drain2_ready", 32'(bus.md_ready), 1);
      tick();
      mid();
      check("drain_done_we", 32'(bus.grf_we), 0);
      check("drain_done_pending", 32'(bus.md_pending), 0);
      tick();

      // starvation guard: one queued entry against continuous WB
      set_wb(1, 5'd4, 32'h4444, 32'h7000);
      set_md(1, 5'd9, 32'h9999, 32'h8000);
      tick();
      set_md(0, 0, 0, 0);
      for (int k = 1; k <= 6; k++) begin
         mid();
         if (GUARD && k == 5) begin
            check("guard_force_a3", 32'(bus.grf_a3), 9);
            check("guard_force_stall", 32'(bus.wb_stall), 1);
         end else begin
            check("guard_wb_a3", 32'(bus.grf_a3), 4);
            check("guard_wb_stall", 32'(bus.wb_stall), 0);
         end
         tick();
      end
      set_wb(0, 0, 0, 0);
      mid();
      if (GUARD) check("guard_after_we", 32'(bus.grf_we), 0);
      else       check("noguard_late_a3", 32'(bus.grf_a3), 9);
      tick();

      // reset with 2 entries queued drops them
      set_wb(1, 5'd3, 32'h3333, 32'h5000);
      set_md(1, 5'd11, 32'hBBBB, 32'h9000);
      tick();
      set_md(1, 5'd12, 32'hCCCC, 32'h9004);
      tick();
      reset = 1'b1;
      mid();
      check("rst_grf_we", 32'(bus.grf_we), 0);
      check("rst_md_ready", 32'(bus.md_ready), 0);
      check("rst_wb_stall", 32'(bus.wb_stall), 0);
      check("rst_pending_before", 32'(bus.md_pending), 1);
      tick();
      reset = 1'b0;
      set_wb(0, 0, 0, 0);
      set_md(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         mid();
         check("post_rst_we", 32'(bus.grf_we), 0);
         check("post_rst_ready", 32'(bus.md_ready), 1);
         check("post_rst_pending", 32'(bus.md_pending), 0);
         tick();
      end

      // randomized traffic, model compares every cycle
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(63) == 0);
         set_wb($urandom_range(9) < 6,
                ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31)),
                $urandom, $urandom);
         set_md($urandom_range(1) == 1,
                ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31)),
                $urandom, $urandom);
         tick();
      end
      reset = 1'b0;
      set_wb(0, 0, 0, 0);
      set_md(0, 0, 0, 0);
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/grf_wr_arbiter.md
# grf_wr_arbiter

Shares the single GRF write port between the pipeline writeback stage (WB) and the multiply/divide result path (MD). WB requests are granted immediately by priority. MD results are accepted through a valid/ready handshake into a 2-entry FIFO and drained on cycles where WB does not write. The block sits between the WB stage / MD unit and the GRF write port (we, A3, WD, PC).

## Interface
- STARVE_LIMIT, 4: consecutive cycles a non-empty FIFO may lose to WB before the guard forces an MD grant. Legal range 1..15.

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- wb_we  in  1  WB write request
- wb_a3  in  5  WB destination register
- wb_wd  in  32  WB write data
- wb_pc  in  32  PC of the WB instruction
- wb_stall  out  1  WB write not taken this cycle; pipeline must hold WB
- md_valid  in  1  MD result valid
- md_a3  in  5  MD destination register
- md_wd  in  32  MD result data
- md_pc  in  32  PC of the MD instruction
- md_ready  out  1  FIFO can accept an MD result
- grf_we  out  1  GRF write enable
- grf_a3  out  5  GRF write address
- grf_wd  out  32  GRF write data
- grf_pc  out  32  PC forwarded to the GRF trace
- md_pending  out  1  FIFO non-empty, for the hazard unit

## Operation
- FIFO: 2 entries of {a3, wd, pc}, with registered rd/wr pointers and a 2-bit count. States are EMPTY (0), ONE (1), FULL (2).
- Accept: md_valid && md_ready pushes one entry.
  - md_a3 == 0: the result is accepted but not stored; no write ever occurs.
- md_ready = (count != 2) && !reset. It is a function of registered count only; there is no pass-through when FULL, even if a pop occurs in the same cycle.
- Grant, evaluated combinationally each cycle:
  - Guard forcing (see Configuration) grants the FIFO head and asserts wb_stall.
  - Else if wb_we && wb_a3 != 0: grant WB.
  - Else if count != 0: grant the FIFO head and pop it at the clock edge.
  - Else: grf_we = 0.
- wb_we with wb_a3 == 0 is consumed without a write. grf_we = 0 for that request, and it never stalls.
- Outputs carry the granted source's a3, wd and pc. When grf_we = 0, grf_a3, grf_wd and grf_pc are 0.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Ordering is preserved within each source only. Cross-source WAW ordering is the hazard unit's job via md_pending.
- Reset: pointers, count and the starvation counter clear to 0, and FIFO contents are discarded. During the reset cycle grf_we = 0, md_ready = 0 and wb_stall = 0. A reset asserted with entries queued loses them.

## Timing
- Output values after reset: grf_we 0, grf_a3 0, grf_wd 0, grf_pc 0, md_ready 1 (once reset deasserts), wb_stall 0, md_pending 0.
- WB latency is 0 cycles: the GRF samples at the same posedge.
- MD latency is at least 1 cycle from the accept edge to grf_we. There is no same-cycle bypass from md inputs to the grf port.
- Throughput is one GRF write per cycle. md_ready falls the cycle after the second unpopped accept.
- All outputs are combinational from registered state plus the wb_* inputs. There are no combinational paths from md_* inputs to outputs.

## Configuration
- GRF_ARB_STARVE_GUARD_EN defined:
  - A 4-bit starve_cnt increments on every cycle where count != 0 and WB is granted.
  - It clears on any FIFO grant, and when count is 0.
  - When starve_cnt == STARVE_LIMIT, the next cycle with count != 0 grants the FIFO head regardless of wb_we. In that cycle wb_stall = wb_we && wb_a3 != 0, and starve_cnt clears.
  - The stalled WB request is re-presented unchanged by the pipeline and granted the following cycle.
- GRF_ARB_STARVE_GUARD_EN undefined:
  - WB has strict priority.
  - wb_stall is tied 0 and no counter exists.
  - The FIFO drains only on WB-idle cycles.

## Test plan
- Reset then idle. Expect md_ready=1, grf_we=0 and md_pending=0 throughout.
- WB only: wb_we=1, a3=5, wd=0x1234, pc=0x3000. Expect grf_we=1, grf_a3=5 and grf_wd=0x1234 in the same cycle. Repeating with a3=0 gives grf_we=0.
- MD with WB idle: accept a3=8, wd=0xAAAA at edge N. Expect grf_we=1, grf_a3=8 in cycle N+1, and md_pending=0 after edge N+1.
- FIFO fill:
  - Accept entries a3=1, then a3=2, with wb_we held at 1 and a3=3; md_ready=0 after the second accept.
  - Drop wb_we. Expect writes to $1, then $2 on consecutive cycles, with md_ready=1 again.
- Guard (macro defined, STARVE_LIMIT=4):
  - One queued entry, wb_we=1 continuously. WB is granted for 4 cycles.
  - 5th cycle: FIFO head granted, wb_stall=1.
  - 6th cycle: WB granted, wb_stall=0.
  - With the macro undefined, the entry waits until wb_we falls.
- Reset with 2 entries queued. The next cycle gives count 0, grf_we=0 and md_ready=1. No queued write ever appears.
